verdict_collector: RTL

- Sits directly downstream of the RTLola monitor `topEntity`.
- Watches the monitor's six output streams (`a`..`f`) with their `_aktv` flags and captures one record per cycle in which any stream is active.
- Buffers records in a small FIFO and serializes them as 64-bit words over a valid/ready stream: one header word, then one payload word per active stream.
- Feeds the host/trace interface; counts records lost to overflow.

---
 rtl/verdict_pkg.sv | 55 +++++
 rtl/verdict_fifo.sv | 65 ++++++
 rtl/verdict_collector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/verdict_pkg.sv
// =============================================================================
// Module   : verdict_pkg
// Summary  : Shared types for verdict_collector. The record carries a timestamp
//            field only when VERDICT_COLLECTOR_TIMESTAMP_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package verdict_pkg;

    localparam int N_STREAMS    = 6;
    localparam int VAL_W        = 64;
    localparam int HDR_TS_LSB   = 32;
    localparam int HDR_TS_W     = 32;
    localparam int HDR_CNT_LSB  = 8;
    localparam int HDR_CNT_W    = 8;
    localparam int HDR_MASK_LSB = 0;

    typedef logic [N_STREAMS-1:0] mask_t;

    typedef struct packed {
        mask_t                             mask;
`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
        logic [HDR_TS_W-1:0]               ts;
`endif
        logic [N_STREAMS-1:0][VAL_W-1:0]   values;
    } record_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    function automatic logic [HDR_CNT_W-1:0] popcount(input mask_t m);
        logic [HDR_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            n = n + {{(HDR_CNT_W-1){1'b0}}, m[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] lowest_set(input mask_t m);
        logic [2:0] idx;
        idx = '0;
        for (int i = N_STREAMS - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/verdict_fifo.sv
// =============================================================================
// Module   : verdict_fifo
// Summary  : Synchronous record FIFO; head record is read straight from the
//            storage registers. Reset is synchronous, active-low.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module verdict_fifo
    import verdict_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  record_t                      i_data,
    input  logic                         i_pop,
    output record_t                      o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    record_t              r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 w_wr;
    logic                 w_rd;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/verdict_collector.sv
// =============================================================================
// Module   : verdict_collector
// Summary  : Captures active monitor streams into records and serializes them
//            as header + payload words. Timestamps: VERDICT_COLLECTOR_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module verdict_collector
    import verdict_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [63:0]           out_a,
    input  logic signed [63:0]           out_b,
    input  logic signed [63:0]           out_c,
    input  logic signed [63:0]           out_d,
    input  logic signed [63:0]           out_e,
    input  logic signed [63:0]           out_f,
    input  logic                         out_a_aktv,
    input  logic                         out_b_aktv,
    input  logic                         out_c_aktv,
    input  logic                         out_d_aktv,
    input  logic                         out_e_aktv,
    input  logic                         out_f_aktv,
    output logic [63:0]                  m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic [DROP_W-1:0]            drop_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int LVL_W = $clog2(DEPTH+1);

    mask_t       w_mask;
    record_t     w_wr_rec;
    record_t     w_head;
    logic        w_push_req;
    logic        w_push_ok;
    logic        w_full;
    logic        w_empty;
    logic        w_hs;
    logic        w_last_pay;
    logic        w_pop;
    state_t      r_state;
    state_t      w_state_nxt;
    mask_t       r_rem;
    mask_t       w_rem_nxt;
    logic [DROP_W-1:0] r_drop;

    assign w_mask     = {out_f_aktv, out_e_aktv, out_d_aktv, out_c_aktv, out_b_aktv, out_a_aktv};
    assign w_push_req = rst && en && (w_mask != '0);
    assign w_push_ok  = w_push_req && !w_full;

`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (!rst)    r_ts <= '0;
        else if (en) r_ts <= r_ts + 1'b1;
    end
`endif

    always_comb begin
        w_wr_rec.mask   = w_mask;
`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
        w_wr_rec.ts     = HDR_TS_W'(r_ts);
`endif
        w_wr_rec.values = {out_f, out_e, out_d, out_c, out_b, out_a};
    end

    verdict_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_ok),
        .i_data  (w_wr_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // The full check looks at the registered level, so a pop in the same cycle does not rescue a push.
    always_ff @(posedge clk) begin
        if (!rst)                               r_drop <= '0;
        else if (w_push_req && w_full && !(&r_drop)) r_drop <= r_drop + 1'b1;
    end

    assign drop_count = r_drop;

    // r_rem holds the payload streams not yet sent; its lowest set bit is the current word.
    assign w_hs       = m_valid && m_ready;
    assign w_last_pay = (r_state == PAY) && ((r_rem & (r_rem - 1'b1)) == '0);
    assign w_pop      = w_hs && w_last_pay;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (!w_empty || w_push_ok) w_state_nxt = HDR;
            end
            HDR: begin
                if (w_hs) begin
                    w_state_nxt = PAY;
                    w_rem_nxt   = w_head.mask;
                end
            end
            PAY: begin
                if (w_hs) begin
                    w_rem_nxt = r_rem & (r_rem - 1'b1);
                    if (w_last_pay) begin
                        w_state_nxt = ((fifo_level > LVL_W'(1)) || w_push_ok) ? HDR : IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    assign m_valid = (r_state != IDLE);
    assign m_last  = w_last_pay;

    always_comb begin
        m_data = '0;
        case (r_state)
            HDR: begin
`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
                m_data[HDR_TS_LSB +: HDR_TS_W]    = w_head.ts;
`endif
                m_data[HDR_CNT_LSB +: HDR_CNT_W]  = popcount(w_head.mask);
                m_data[HDR_MASK_LSB +: N_STREAMS] = w_head.mask;
            end
            PAY:     m_data = w_head.values[lowest_set(r_rem)];
            default: m_data = '0;
        endcase
    end

endmodule

`default_nettype wire
